// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the single-stage RV core.
//
// Holds the fetch PC, runs a valid/ready handshake with the instruction-fetch
// port, and applies redirects in priority order trap > mret > jalr > br_jal >
// sequential. A taken jump that arrives while the fetch is not accepted is
// buffered in pend_pc until the handshake fires. Misaligned jump targets are
// rejected and reported for one cycle.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-low reset
//   stall            hold PC; blocks sequential and jump advance
//   imm              immediate for jal/branch target (pc+imm)
//   alu_out          jalr target before bit-0 clear
//   br_jal           taken branch or jal request
//   jalr             jalr request
//   trap, trap_vec   exception/interrupt entry and its vector
//   mret, mepc       trap return and saved PC
//   if_ready         fetch port accepts the current pc
//   if_req           pc is valid for fetch
//   pc               current PC
//   normal_pc        pc+4 (link value)
//   jal_branch_pc    pc+imm
//   redirect_pending a buffered jump target is waiting
//   misalign         rejected jump target this cycle
//   misalign_addr    offending target, valid with misalign
//
// state | meaning
// BOOT  | after reset, pc=RESET_VECTOR, no fetch request
// RUN   | fetching, if_req=1
module pc_gen #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int               IALIGN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_out,
  input  logic            br_jal,
  input  logic            jalr,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            mret,
  input  logic [XLEN-1:0] mepc,
  input  logic            if_ready,
  output logic            if_req,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] normal_pc,
  output logic [XLEN-1:0] jal_branch_pc,
  output logic            redirect_pending,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic            pend_valid, pend_valid_nxt;
  logic [XLEN-1:0] pend_pc, pend_pc_nxt;
  logic [XLEN-1:0] jump_target;
  logic            jump_req;
  logic            target_bad;
  logic            fire;

  assign normal_pc        = pc + XLEN'(4);
  assign jal_branch_pc    = pc + imm;
  assign redirect_pending = pend_valid;
  assign if_req           = (state == RUN);
  assign fire             = if_req & if_ready & ~stall;

  assign jump_req    = jalr | br_jal;
  assign jump_target = jalr ? {alu_out[XLEN-1:1], 1'b0} : jal_branch_pc;

  generate
    if (IALIGN == 16) begin : g_align16
      assign target_bad = jump_target[0];
    end else begin : g_align32
      assign target_bad = |jump_target[1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= BOOT;
      pc         <= RESET_VECTOR;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pend_valid <= pend_valid_nxt;
      pend_pc    <= pend_pc_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    pend_valid_nxt = pend_valid;
    pend_pc_nxt    = pend_pc;
    misalign       = 1'b0;
    misalign_addr  = '0;

    if (trap) begin
      state_nxt      = RUN;
      pc_nxt         = {trap_vec[XLEN-1:1], 1'b0};
      pend_valid_nxt = 1'b0;
    end else if (mret) begin
      state_nxt      = RUN;
      pc_nxt         = {mepc[XLEN-1:1], 1'b0};
      pend_valid_nxt = 1'b0;
    end else if (state == BOOT) begin
      state_nxt = RUN;
    end else if (pend_valid) begin
      // the jump source is still being held; only the buffered target matters
      if (fire) begin
        pc_nxt         = pend_pc;
        pend_valid_nxt = 1'b0;
      end
    end else if (jump_req) begin
      if (target_bad) begin
        misalign      = rst;
        misalign_addr = rst ? jump_target : '0;
      end else if (fire) begin
        pc_nxt = jump_target;
      end else begin
        pend_pc_nxt    = jump_target;
        pend_valid_nxt = 1'b1;
      end
    end else if (fire) begin
      pc_nxt = normal_pc;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] imm;
  logic [31:0] alu_out;
  logic        br_jal;
  logic        jalr;
  logic        trap;
  logic [31:0] trap_vec;
  logic        mret;
  logic [31:0] mepc;
  logic        if_ready;

  logic        if_req, redirect_pending, misalign;
  logic [31:0] pc, normal_pc, jal_branch_pc, misalign_addr;
  logic        h_if_req, h_redirect_pending, h_misalign;
  logic [31:0] h_pc, h_normal_pc, h_jal_branch_pc, h_misalign_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .imm(imm), .alu_out(alu_out),
    .br_jal(br_jal), .jalr(jalr), .trap(trap), .trap_vec(trap_vec),
    .mret(mret), .mepc(mepc), .if_ready(if_ready), .if_req(if_req), .pc(pc),
    .normal_pc(normal_pc), .jal_branch_pc(jal_branch_pc),
    .redirect_pending(redirect_pending), .misalign(misalign),
    .misalign_addr(misalign_addr)
  );

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(16)) dut16 (
    .clk(clk), .rst(rst), .stall(stall), .imm(imm), .alu_out(alu_out),
    .br_jal(br_jal), .jalr(jalr), .trap(trap), .trap_vec(trap_vec),
    .mret(mret), .mepc(mepc), .if_ready(if_ready), .if_req(h_if_req), .pc(h_pc),
    .normal_pc(h_normal_pc), .jal_branch_pc(h_jal_branch_pc),
    .redirect_pending(h_redirect_pending), .misalign(h_misalign),
    .misalign_addr(h_misalign_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; imm = '0; alu_out = '0; br_jal = 1'b0;
    jalr = 1'b0; trap = 1'b0; trap_vec = '0; mret = 1'b0; mepc = '0;
    if_ready = 1'b1;
    tick(); tick();
    chk("reset_pc", pc, 32'h0);
    chk("reset_if_req", {31'b0, if_req}, 32'd0);
    chk("reset_pending", {31'b0, redirect_pending}, 32'd0);
    chk("reset_misalign", {31'b0, misalign}, 32'd0);
    chk("reset_misalign_addr", misalign_addr, 32'h0);

    // release: one edge to RUN, pc still at reset vector
    rst = 1'b1;
    tick();
    chk("boot_if_req", {31'b0, if_req}, 32'd1);
    chk("boot_pc", pc, 32'h0);
    tick(); chk("seq_pc4", pc, 32'h4);
    tick(); chk("seq_pc8", pc, 32'h8);
    tick(); chk("seq_pc12", pc, 32'hC);
    tick(); chk("seq_pc16", pc, 32'h10);
    chk("normal_pc_16", normal_pc, 32'h14);

    // jump while fetch is back-pressured: buffered for three cycles
    br_jal = 1'b1; imm = 32'h20; if_ready = 1'b0;
    #1 chk("jal_branch_pc", jal_branch_pc, 32'h30);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pend_hold_pending", {31'b0, redirect_pending}, 32'd1);
      chk("pend_hold_pc", pc, 32'h10);
      chk("pend_hold_if_req", {31'b0, if_req}, 32'd1);
    end
    if_ready = 1'b1;
    tick();
    br_jal = 1'b0; imm = '0;
    chk("pend_fire_pc", pc, 32'h30);
    chk("pend_fire_pending", {31'b0, redirect_pending}, 32'd0);

    // jalr clears bit 0 of the sum
    jalr = 1'b1; alu_out = 32'h101;
    #1 chk("jalr_ok_misalign", {31'b0, misalign}, 32'd0);
    tick();
    chk("jalr_ok_pc", pc, 32'h100);
    chk("jalr_ok_pc16", h_pc, 32'h100);

    // 0x102 is misaligned only for 32-bit alignment
    alu_out = 32'h102;
    #1;
    chk("jalr_bad_misalign", {31'b0, misalign}, 32'd1);
    chk("jalr_bad_addr", misalign_addr, 32'h102);
    chk("jalr_16_misalign", {31'b0, h_misalign}, 32'd0);
    tick();
    jalr = 1'b0; alu_out = '0;
    chk("jalr_bad_pc", pc, 32'h100);
    chk("jalr_16_pc", h_pc, 32'h102);

    // held misaligned branch re-pulses and never enters the buffer
    br_jal = 1'b1; imm = 32'h2;
    #1;
    chk("br_bad_misalign1", {31'b0, misalign}, 32'd1);
    chk("br_bad_addr1", misalign_addr, 32'h102);
    tick();
    chk("br_bad_misalign2", {31'b0, misalign}, 32'd1);
    chk("br_bad_pc", pc, 32'h100);
    chk("br_bad_pending", {31'b0, redirect_pending}, 32'd0);
    br_jal = 1'b0; imm = '0;
    #1 chk("br_bad_clear", {31'b0, misalign}, 32'd0);

    // buffer a jump, then trap with competing jump and stall
    br_jal = 1'b1; imm = 32'h40; if_ready = 1'b0;
    tick();
    chk("trap_pre_pending", {31'b0, redirect_pending}, 32'd1);
    trap = 1'b1; trap_vec = 32'h80; stall = 1'b1;
    tick();
    trap = 1'b0; br_jal = 1'b0; imm = '0;
    chk("trap_pc", pc, 32'h80);
    chk("trap_pending", {31'b0, redirect_pending}, 32'd0);

    // mret under back-pressure; bit 0 of mepc is dropped
    mret = 1'b1; mepc = 32'h45;
    tick();
    mret = 1'b0; stall = 1'b0; if_ready = 1'b1;
    chk("mret_pc", pc, 32'h44);

    // stall with ready is not a fire
    stall = 1'b1;
    tick();
    stall = 1'b0;
    chk("stall_pc", pc, 32'h44);

    // wrap at the top of the address space
    mret = 1'b1; mepc = 32'hFFFF_FFFC;
    tick();
    mret = 1'b0;
    chk("wrap_pre_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pre_normal", normal_pc, 32'h0);
    tick();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_normal", normal_pc, 32'h4);

    // reset discards a buffered jump
    br_jal = 1'b1; imm = 32'h100; if_ready = 1'b0;
    tick();
    chk("rst_pre_pending", {31'b0, redirect_pending}, 32'd1);
    rst = 1'b0;
    tick();
    br_jal = 1'b0; imm = '0; if_ready = 1'b1;
    chk("rst_mid_pc", pc, 32'h0);
    chk("rst_mid_pending", {31'b0, redirect_pending}, 32'd0);
    chk("rst_mid_if_req", {31'b0, if_req}, 32'd0);

    // trap taken straight out of BOOT
    rst = 1'b1; trap = 1'b1; trap_vec = 32'h201;
    tick();
    trap = 1'b0;
    chk("boot_trap_pc", pc, 32'h200);
    chk("boot_trap_if_req", {31'b0, if_req}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
